// File: rtl/fetch_unit.sv
// fetch_unit: PMP-gated instruction fetch with a DEPTH-entry valid/ready buffer.
// Defining FETCH_PERF_EN adds the perf_fetched / perf_stall saturating counters.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              pmp_x_ok,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              fault_valid,
    output logic [1:0]        fault_cause,
`ifdef FETCH_PERF_EN
    output logic [ADDR_W-1:0] fault_pc,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall
`else
    output logic [ADDR_W-1:0] fault_pc
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] buf_pc [DEPTH];
    logic [31:0]       buf_instr [DEPTH];
    logic              pop, can_fetch, attempt, push, deny, misalign;

    assign imem_addr = pc;
    assign out_valid = count != '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr] : '0;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    assign can_fetch = (state == RUN) & ((count != CW'(DEPTH)) | pop);
    assign attempt   = can_fetch & ~redirect_valid;
    assign push      = attempt & pmp_x_ok;
    assign deny      = attempt & ~pmp_x_ok;
    assign misalign  = redirect_valid & (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        state_nxt = redirect_valid ? (misalign ? HALT : RUN) : (deny ? HALT : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // A redirect flushes the buffer and drops any same-cycle pop or push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fault_valid <= 1'b0;
            fault_cause <= 2'b00;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fault_valid <= misalign;
            fault_cause <= misalign ? 2'b10 : 2'b00;
            if (misalign) fault_pc <= redirect_pc;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (deny) begin
                fault_valid <= 1'b1;
                fault_cause <= 2'b01;
                fault_pc    <= pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= imem_instr;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
            if (state == RUN && !can_fetch && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle checks plus a scoreboard for buffered delivery.
module tb_fetch_unit;
    logic        clk, rst_n;
    logic [7:0]  imem_addr, redirect_pc, out_pc, fault_pc, deny_addr;
    logic [31:0] imem_instr, out_instr;
    logic        pmp_x_ok, redirect_valid, out_valid, out_ready, fault_valid, deny_en;
    logic [1:0]  fault_cause;
    logic [31:0] mem [64];
    int          total, passed;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic        redir;
        logic [7:0]  rpc;
        logic        rdy;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] ei;
        logic [7:0]  ea;
        logic        efv;
        logic [1:0]  efc;
        logic [7:0]  efpc;
    } vec_t;
    vec_t tbl [10];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .pmp_x_ok(pmp_x_ok), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_pc(fault_pc)
    );

    assign imem_instr = mem[imem_addr[7:2]];
    assign pmp_x_ok   = !(deny_en && imem_addr == deny_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_out_pc", 32'(out_pc), 32'h00);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_fault_valid", 32'(fault_valid), 32'd0);
        chk("rst_fault_cause", 32'(fault_cause), 32'd0);
        chk("rst_fault_pc", 32'(fault_pc), 32'h00);
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        deny_en = 1'b0; deny_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input logic [7:0] pc, input logic [31:0] instr);
        sb.push_back('{pc, instr});
    endtask

    task automatic drain(input int bound);
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready && !redirect_valid) begin
                e = sb.pop_front();
                chk("sb_pc", 32'(out_pc), 32'(e.pc));
                chk("sb_instr", out_instr, e.instr);
            end
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d entries still pending, expected 0", sb.size());
            sb.delete();
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        mem[0] = 32'h0800_0293; mem[1] = 32'h0400_0313;
        mem[2] = 32'h0000_0393; mem[8] = 32'h0031_01B3;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        deny_en = 1'b0; deny_addr = 8'h00;

        // streaming, misaligned redirect, and wrap at the top of the address space
        tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'h00, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0800_0293, 8'h04, 1'b0, 2'd0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h0400_0313, 8'h08, 1'b0, 2'd0, 8'h00};
        tbl[3] = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h08, 32'h0000_0393, 8'h0C, 1'b0, 2'd0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'h42, 1'b1, 2'd2, 8'h42};
        tbl[5] = '{1'b1, 8'hF8, 1'b1, 1'b0, 8'h00, 32'h0,         8'h42, 1'b1, 2'd2, 8'h42};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,         8'hF8, 1'b0, 2'd0, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hF8, 32'hC0DE_003E, 8'hFC, 1'b0, 2'd0, 8'h00};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFC, 32'hC0DE_003F, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0800_0293, 8'h04, 1'b0, 2'd0, 8'h00};

        rst_n = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].ea));
            chk($sformatf("t%0d_fv", i), 32'(fault_valid), 32'(tbl[i].efv));
            chk($sformatf("t%0d_fc", i), 32'(fault_cause), 32'(tbl[i].efc));
            if (tbl[i].ev) begin
                chk($sformatf("t%0d_pc", i), 32'(out_pc), 32'(tbl[i].epc));
                chk($sformatf("t%0d_instr", i), out_instr, tbl[i].ei);
            end
            if (tbl[i].efv) chk($sformatf("t%0d_fpc", i), 32'(fault_pc), 32'(tbl[i].efpc));
            tick();
        end
        redirect_valid = 1'b0;

        // back-pressure: buffer fills with 0x00/0x04, pc parks at 0x08
        do_reset();
        repeat (5) tick();
        chk("bp_addr", 32'(imem_addr), 32'h08);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_pc", 32'(out_pc), 32'h00);
        chk("bp_hold_instr", out_instr, 32'h0800_0293);
        expect_out(8'h00, 32'h0800_0293);
        expect_out(8'h04, 32'h0400_0313);
        expect_out(8'h08, 32'h0000_0393);
        expect_out(8'h0C, 32'hC0DE_0003);
        out_ready = 1'b1;
        drain(20);

        // PMP deny after redirect, then recovery by aligned redirect
        do_reset();
        deny_en = 1'b1; deny_addr = 8'h80;
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("pmp_fv", 32'(fault_valid), 32'd1);
        chk("pmp_fc", 32'(fault_cause), 32'd1);
        chk("pmp_fpc", 32'(fault_pc), 32'h80);
        chk("pmp_valid", 32'(out_valid), 32'd0);
        repeat (3) tick();
        chk("pmp_addr_hold", 32'(imem_addr), 32'h80);
        chk("pmp_fv_hold", 32'(fault_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        chk("pmp_clear_fv", 32'(fault_valid), 32'd0);
        chk("pmp_clear_fc", 32'(fault_cause), 32'd0);
        expect_out(8'h00, 32'h0800_0293);
        out_ready = 1'b1;
        drain(10);

        // denied address held under back-pressure faults only when fetch is attempted
        do_reset();
        deny_en = 1'b1; deny_addr = 8'h08;
        repeat (4) tick();
        chk("bpd_no_fault", 32'(fault_valid), 32'd0);
        chk("bpd_addr", 32'(imem_addr), 32'h08);
        expect_out(8'h00, 32'h0800_0293);
        expect_out(8'h04, 32'h0400_0313);
        out_ready = 1'b1;
        drain(10);
        chk("bpd_fv", 32'(fault_valid), 32'd1);
        chk("bpd_fc", 32'(fault_cause), 32'd1);
        chk("bpd_fpc", 32'(fault_pc), 32'h08);
        chk("bpd_drained", 32'(out_valid), 32'd0);

        // redirect while full and being popped: flushed entries never delivered
        do_reset();
        repeat (3) tick();
        chk("fl_full", 32'(out_valid), 32'd1);
        expect_out(8'h20, 32'h0031_01B3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect_valid = 1'b0;
        chk("fl_flushed", 32'(out_valid), 32'd0);
        drain(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
